// File: rtl/axis_throttle_fifo.sv
// AXI-Stream elastic buffer with first-word fall-through output, fill/packet
// counters and an optional periodic ready-throttle on the input side.
module axis_throttle_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned READY_ON  = 3,
  parameter int unsigned READY_OFF = 2,
  parameter int unsigned LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              thr_en,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [LVL_W-1:0]  level,
  output logic [LVL_W-1:0]  pkt_cnt
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned Period = READY_ON + READY_OFF;
  localparam int unsigned CntW   = (Period > 1) ? $clog2(Period) : 1;

  // Each entry holds {last, data}
  logic [DATA_W:0]   mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LVL_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CntW-1:0]   thr_cnt_q, thr_cnt_d;
  logic              s_ready_q, s_ready_d;
  logic              window_d;
  logic              push, pop;
  logic [DATA_W:0]   head;

  assign head    = mem_q[rd_ptr_q];
  assign m_valid = (level_q != '0);
  // Outputs are forced to zero while empty so stale entries never leak out
  assign m_data  = m_valid ? head[DATA_W-1:0] : '0;
  assign m_last  = m_valid ? head[DATA_W] : 1'b0;
  assign s_ready = s_ready_q;
  assign level   = level_q;
  assign pkt_cnt = pkt_cnt_q;

  assign push = s_valid & s_ready_q;
  assign pop  = m_valid & m_ready;

  // Pointer, level and packet-count next-state
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkt_cnt_d = pkt_cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    unique case ({push & s_last, pop & m_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + LVL_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - LVL_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // Throttle counter and registered ready; ready looks only at next-state so
  // m_ready never reaches s_ready combinationally
  always_comb begin
    thr_cnt_d = '0;
    window_d  = 1'b1;
    if (thr_en) begin
      thr_cnt_d = (thr_cnt_q == CntW'(Period - 1)) ? '0 : thr_cnt_q + CntW'(1);
    end
    if (READY_OFF != 0) begin
      window_d = (32'(thr_cnt_d) < READY_ON);
    end
    s_ready_d = (32'(level_d) < DEPTH) && window_d;
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkt_cnt_q <= '0;
      thr_cnt_q <= '0;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
      thr_cnt_q <= thr_cnt_d;
      s_ready_q <= s_ready_d;
    end
  end

  // Storage write; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_last, s_data};
    end
  end

endmodule

// File: tb/tb_axis_throttle_fifo.sv
// Directed bench for axis_throttle_fifo: vector table plus hand sequences for
// throttle pattern and asynchronous reset.
module tb_axis_throttle_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       thr_en;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_last;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic [2:0] level;
  logic [2:0] pkt_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       thr_en;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_ready;
    logic       e_s_ready;
    logic       e_m_valid;
    logic [7:0] e_m_data;
    logic       e_m_last;
    logic [2:0] e_level;
    logic [2:0] e_pkt;
  } vec_t;

  vec_t tbl[$];

  axis_throttle_fifo #(
    .DATA_W   (8),
    .DEPTH    (4),
    .READY_ON (3),
    .READY_OFF(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .thr_en (thr_en),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_last (s_last),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last (m_last),
    .level  (level),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic thr, input logic sv, input logic [7:0] sd,
                              input logic sl, input logic mr, input logic er,
                              input logic emv, input logic [7:0] emd, input logic eml,
                              input logic [2:0] elv, input logic [2:0] ep);
    vec_t v;
    v = '{thr, sv, sd, sl, mr, er, emv, emd, eml, elv, ep};
    tbl.push_back(v);
  endfunction

  // Drive one vector, clock once, check all outputs shortly after the edge
  task automatic apply(input vec_t v, input int idx);
    thr_en  = v.thr_en;
    s_valid = v.s_valid;
    s_data  = v.s_data;
    s_last  = v.s_last;
    m_ready = v.m_ready;
    @(posedge clk);
    #1;
    check("s_ready", idx, 32'(s_ready), 32'(v.e_s_ready));
    check("m_valid", idx, 32'(m_valid), 32'(v.e_m_valid));
    check("m_data",  idx, 32'(m_data),  32'(v.e_m_data));
    check("m_last",  idx, 32'(m_last),  32'(v.e_m_last));
    check("level",   idx, 32'(level),   32'(v.e_level));
    check("pkt_cnt", idx, 32'(pkt_cnt), 32'(v.e_pkt));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_s_ready"}, 0, 32'(s_ready), 32'd0);
    check({name, "_m_valid"}, 0, 32'(m_valid), 32'd0);
    check({name, "_m_data"},  0, 32'(m_data),  32'd0);
    check({name, "_m_last"},  0, 32'(m_last),  32'd0);
    check({name, "_level"},   0, 32'(level),   32'd0);
    check({name, "_pkt_cnt"}, 0, 32'(pkt_cnt), 32'd0);
  endtask

  initial begin
    int   accepted;
    logic took;
    logic [7:0] pushed;
    vec_t v;

    rst_n = 1'b0; thr_en = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b0;

    // Streaming with m_ready=1: each word visible right after its accept
    for (int k = 1; k <= 16; k++) begin
      add(0, 1, 8'(k), 0, 1,  1, 1, 8'(k), 0, 3'd1, 3'd0);
    end
    add(0, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 3'd0, 3'd0);
    // Fill to full with m_ready=0
    add(0, 1, 8'hA1, 0, 0,  1, 1, 8'hA1, 0, 3'd1, 3'd0);
    add(0, 1, 8'hA2, 0, 0,  1, 1, 8'hA1, 0, 3'd2, 3'd0);
    add(0, 1, 8'hA3, 0, 0,  1, 1, 8'hA1, 0, 3'd3, 3'd0);
    add(0, 1, 8'hA4, 0, 0,  0, 1, 8'hA1, 0, 3'd4, 3'd0);
    // Valid while not ready is ignored
    add(0, 1, 8'hEE, 0, 0,  0, 1, 8'hA1, 0, 3'd4, 3'd0);
    // One pop re-opens ready, then drain
    add(0, 0, 8'h00, 0, 1,  1, 1, 8'hA2, 0, 3'd3, 3'd0);
    add(0, 0, 8'h00, 0, 1,  1, 1, 8'hA3, 0, 3'd2, 3'd0);
    add(0, 0, 8'h00, 0, 1,  1, 1, 8'hA4, 0, 3'd1, 3'd0);
    add(0, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 3'd0, 3'd0);
    // Packet with last on third word
    add(0, 1, 8'h10, 0, 0,  1, 1, 8'h10, 0, 3'd1, 3'd0);
    add(0, 1, 8'h11, 0, 0,  1, 1, 8'h10, 0, 3'd2, 3'd0);
    add(0, 1, 8'h12, 1, 0,  1, 1, 8'h10, 0, 3'd3, 3'd1);
    add(0, 0, 8'h00, 0, 1,  1, 1, 8'h11, 0, 3'd2, 3'd1);
    add(0, 0, 8'h00, 0, 1,  1, 1, 8'h12, 1, 3'd1, 3'd1);
    add(0, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 3'd0, 3'd0);

    // Reset held from time 0
    @(posedge clk);
    #1;
    check_all_zero("in_reset");
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_s_ready", 0, 32'(s_ready), 32'd1);
    check("rel_level",   0, 32'(level),   32'd0);
    check("rel_m_valid", 0, 32'(m_valid), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Throttle: ready pattern 1,1,1,0,0 and 3 accepts per 5 cycles
    thr_en = 1'b1; s_valid = 1'b1; m_ready = 1'b1; s_last = 1'b0; s_data = 8'h40;
    accepted = 0;
    for (int j = 0; j < 15; j++) begin
      check("thr_s_ready", j, 32'(s_ready), 32'((j % 5) < 3));
      took   = s_ready;
      pushed = s_data;
      @(posedge clk);
      #1;
      if (took) begin
        accepted++;
        check("thr_m_data", j, 32'(m_data), 32'(pushed));
        s_data = s_data + 8'd1;
      end
    end
    check("thr_accepted", 0, 32'(accepted), 32'd9);
    v = '{0, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 3'd0, 3'd0};
    apply(v, 100);

    // Simultaneous push and pop keeps level at 2
    v = '{0, 1, 8'h21, 0, 0,  1, 1, 8'h21, 0, 3'd1, 3'd0}; apply(v, 200);
    v = '{0, 1, 8'h22, 0, 0,  1, 1, 8'h21, 0, 3'd2, 3'd0}; apply(v, 201);
    v = '{0, 1, 8'h23, 0, 1,  1, 1, 8'h22, 0, 3'd2, 3'd0}; apply(v, 202);
    v = '{0, 0, 8'h00, 0, 0,  1, 1, 8'h22, 0, 3'd2, 3'd0}; apply(v, 203);

    // Mid-cycle reset with words stored clears outputs at once
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #2 rst_n = 1'b1;
    v = '{0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 3'd0, 3'd0}; apply(v, 300);
    v = '{0, 1, 8'h55, 0, 0,  1, 1, 8'h55, 0, 3'd1, 3'd0}; apply(v, 301);
    v = '{0, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 3'd0, 3'd0}; apply(v, 302);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
